// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial transmitter: start bit, LSB-first data, optional even parity, stop bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // serial_out is loaded one edge ahead of each bit so the pad sees a flop output.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            end
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift_reg  <= tx_data;
                        parity_bit <= ^tx_data;
                        bit_cnt    <= '0;
                        baud_cnt   <= '0;
                        serial_out <= 1'b0;
                        tx_ready   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                serial_out <= parity_bit;
                                state      <= PARITY;
                            end else begin
                                serial_out <= 1'b1;
                                state      <= STOP;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + BIT_W'(1);
                            shift_reg  <= shift_reg >> 1;
                            serial_out <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    // Raised one edge early so the pulse lands on the last stop cycle.
                    if (baud_cnt == BAUD_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    tx_ready   <= 1'b1;
                    baud_cnt   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with and without parity
module tb_uart_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b, so_a, so_b, done_a, done_b;
    logic       sel;
    logic       so_s, rdy_s, done_s;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1'b0)) dut_a (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(valid_a),
        .tx_ready(ready_a), .serial_out(so_a), .tx_done(done_a));

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1'b1)) dut_b (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(valid_b),
        .tx_ready(ready_b), .serial_out(so_b), .tx_done(done_b));

    assign so_s   = sel ? so_b : so_a;
    assign rdy_s  = sel ? ready_b : ready_a;
    assign done_s = sel ? done_b : done_a;

    int   checks = 0;
    int   failures = 0;
    logic line [0:127];
    logic dn   [0:127];
    logic rdy  [0:127];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_valid(input logic v);
        if (sel) valid_b = v;
        else     valid_a = v;
    endtask

    // kind 1: pulse tx_valid with 0x12; kind 2: one reset edge; kind 3: change tx_data.
    task automatic send(input logic [7:0] d, input int ncyc, input int act_cyc,
                        input int act_kind, input int drop_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        tx_data = d;
        drive_valid(1'b1);
        while (rdy_s !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(waited < 200), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            line[c] = so_s;
            dn[c]   = done_s;
            rdy[c]  = rdy_s;
            if (c == drop_cyc) drive_valid(1'b0);
            if (act_kind == 1 && c == act_cyc) begin
                tx_data = 8'h12;
                drive_valid(1'b1);
            end
            if (act_kind == 1 && c == act_cyc + 1) drive_valid(1'b0);
            if (act_kind == 2 && c == act_cyc) n_rst = 1'b0;
            if (act_kind == 2 && c == act_cyc + 1) n_rst = 1'b1;
            if (act_kind == 3 && c == act_cyc) tx_data = 8'hFF;
        end
        drive_valid(1'b0);
    endtask

    function automatic logic [15:0] bits_at(input int start, input int n);
        logic [15:0] v;
        v = '0;
        for (int j = 0; j < n; j++) v[j] = line[start + j * C];
        return v;
    endfunction

    function automatic int unstable(input int start, input int n);
        int e;
        e = 0;
        for (int c = start; c < start + n * C; c++)
            if (line[c] !== line[start + ((c - start) / C) * C]) e++;
        return e;
    endfunction

    function automatic int done_count(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c <= b; c++) if (dn[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic idle_watch(input string tag, input int ncyc);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (so_s !== 1'b1 || rdy_s !== 1'b1 || done_s !== 1'b0) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        sel = 1'b0;
        n_rst = 1'b0;
        tx_data = 8'h00;
        valid_a = 1'b1;
        valid_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_serial_a", 32'(so_a), 32'd1);
        check("rst_ready_a", 32'(ready_a), 32'd1);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_serial_b", 32'(so_b), 32'd1);
        n_rst = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (so_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) bad++;
            if (so_b !== 1'b1 || ready_b !== 1'b1 || done_b !== 1'b0) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);

        send(8'hA5, 41, 0, 0, 1);
        check("a5_bits", 32'(bits_at(1, 10)), 32'h34A);
        check("a5_stable", 32'(unstable(1, 10)), 32'd0);
        check("a5_done_k40", 32'(dn[40]), 32'd1);
        check("a5_done_count", 32'(done_count(1, 41)), 32'd1);
        check("a5_ready_k40", 32'(rdy[40]), 32'd0);
        check("a5_ready_k41", 32'(rdy[41]), 32'd1);

        sel = 1'b1;
        send(8'h07, 45, 0, 0, 1);
        check("p07_bits", 32'(bits_at(1, 11)), 32'h60E);
        check("p07_parity", 32'(line[37]), 32'd1);
        check("p07_stable", 32'(unstable(1, 11)), 32'd0);
        check("p07_done_k44", 32'(dn[44]), 32'd1);
        check("p07_done_count", 32'(done_count(1, 45)), 32'd1);
        check("p07_ready_k45", 32'(rdy[45]), 32'd1);
        send(8'h03, 45, 0, 0, 1);
        check("p03_bits", 32'(bits_at(1, 11)), 32'h406);
        check("p03_parity", 32'(line[37]), 32'd0);
        check("p03_done_k44", 32'(dn[44]), 32'd1);

        sel = 1'b0;
        send(8'h55, 82, 5, 3, 42);
        check("b2b_first_bits", 32'(bits_at(1, 10)), 32'h2AA);
        check("b2b_first_stable", 32'(unstable(1, 10)), 32'd0);
        check("b2b_gap_high", 32'(line[41]), 32'd1);
        check("b2b_second_start", 32'(line[42]), 32'd0);
        check("b2b_second_bits", 32'(bits_at(42, 10)), 32'h3FE);
        check("b2b_second_stable", 32'(unstable(42, 10)), 32'd0);
        check("b2b_done1", 32'(dn[40]), 32'd1);
        check("b2b_done2", 32'(dn[81]), 32'd1);
        check("b2b_done_count", 32'(done_count(1, 82)), 32'd2);
        idle_watch("b2b_no_third", 12);

        send(8'hC3, 41, 10, 1, 1);
        check("busy_bits", 32'(bits_at(1, 10)), 32'h386);
        check("busy_stable", 32'(unstable(1, 10)), 32'd0);
        check("busy_done_count", 32'(done_count(1, 41)), 32'd1);
        idle_watch("busy_no_second", 12);

        send(8'hF0, 22, 18, 2, 1);
        check("mid_before_rst", 32'(line[18]), 32'd0);
        check("mid_serial_after", 32'(line[19]), 32'd1);
        check("mid_ready_after", 32'(rdy[19]), 32'd1);
        check("mid_no_done", 32'(done_count(1, 22)), 32'd0);
        check("mid_line_high", 32'({line[20], line[21], line[22]}), 32'h7);
        idle_watch("mid_idle", 8);
        send(8'h3C, 41, 0, 0, 1);
        check("mid_next_bits", 32'(bits_at(1, 10)), 32'h278);
        check("mid_next_done", 32'(dn[40]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
